anotherworld_video_engine: RTL and testbench

//  Responder side of the CPU's video-operation request interface. It executes

---
 rtl/anotherworld_video_engine_pkg.sv | 15 +
 rtl/anotherworld_video_engine_if.sv | 29 ++
 rtl/anotherworld_pixel_counter.sv | 28 ++
 rtl/anotherworld_video_engine.sv | 62 ++++++
 tb/tb_anotherworld_video_engine.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/anotherworld_video_engine_pkg.sv
// anotherworld_video_engine_pkg: shared op codes, FSM states and operand record for the video engine
package anotherworld_video_engine_pkg;
  localparam int PAGE_PIXELS_DEF = 64000;
  localparam int PIX_W_DEF = 16;
  typedef enum logic [1:0] {VOP_FILL = 2'd0, VOP_COPY = 2'd1, VOP_BLIT = 2'd2, VOP_RSVD = 2'd3} vop_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_COPY = 2'd2, S_BLIT = 2'd3} state_e;
  typedef struct packed {
    logic [1:0] page_a;
    logic [1:0] page_b;
    logic [3:0] color;
  } cmd_t;
  function automatic state_e op_state(vop_e op);
    return op == VOP_FILL ? S_FILL : op == VOP_COPY ? S_COPY : op == VOP_BLIT ? S_BLIT : S_IDLE;
  endfunction
endpackage

// File: rtl/anotherworld_video_engine_if.sv
// anotherworld_video_engine_if: CPU command handshake plus page RAM and display buffer ports
interface anotherworld_video_engine_if #(parameter int PIX_W = 16);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_page_a;
  logic [1:0]       cmd_page_b;
  logic [3:0]       cmd_color;
  logic             busy;
  logic             done;
  logic [PIX_W+1:0] page_raddr;
  logic [3:0]       page_rdata;
  logic             page_we;
  logic [PIX_W+1:0] page_waddr;
  logic [3:0]       page_wdata;
  logic             disp_we;
  logic [PIX_W-1:0] disp_waddr;
  logic [3:0]       disp_wdata;
  modport master (
    output cmd_valid, cmd_op, cmd_page_a, cmd_page_b, cmd_color, page_rdata,
    input  cmd_ready, busy, done, page_raddr, page_we, page_waddr, page_wdata,
           disp_we, disp_waddr, disp_wdata
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_page_a, cmd_page_b, cmd_color, page_rdata,
    output cmd_ready, busy, done, page_raddr, page_we, page_waddr, page_wdata,
           disp_we, disp_waddr, disp_wdata
  );
endinterface

// File: rtl/anotherworld_pixel_counter.sv
// anotherworld_pixel_counter: clear/enable pixel index 0..PAGE_PIXELS-1 with a registered last flag
module anotherworld_pixel_counter
  import anotherworld_video_engine_pkg::*;
#(
  parameter int PAGE_PIXELS = PAGE_PIXELS_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [PIX_W-1:0] cnt,
  output logic             last
);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PAGE_PIXELS - 1);
  logic [PIX_W-1:0] nxt;
  assign nxt = last ? '0 : cnt + 1'b1;
  // count up while enabled; last is precomputed so the FSM sees it without an adder in its path
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt  <= '0;
      last <= LAST_PIX == '0;
    end else if (en) begin
      cnt  <= nxt;
      last <= nxt == LAST_PIX;
    end
  end
endmodule

// File: rtl/anotherworld_video_engine.sv
// anotherworld_video_engine: executes fill/copy/blit page operations requested by the VM CPU
module anotherworld_video_engine
  import anotherworld_video_engine_pkg::*;
#(
  parameter int PAGE_PIXELS = PAGE_PIXELS_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input logic                   clk,
  input logic                   reset,
  anotherworld_video_engine_if.slave bus
);
  state_e           state, nxt;
  cmd_t             cmd;
  vop_e             op_in;
  logic             accept, rd_active, wr_valid, last, done_q, cnt_en;
  logic [PIX_W-1:0] pix, wr_pix;
  assign op_in  = vop_e'(bus.cmd_op);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign cnt_en = state == S_FILL || rd_active;
  anotherworld_pixel_counter #(.PAGE_PIXELS(PAGE_PIXELS), .PIX_W(PIX_W)) u_cnt (
    .clk(clk), .reset(reset), .clr(accept), .en(cnt_en), .cnt(pix), .last(last)
  );
  // state register
  always_ff @(posedge clk) state <= reset ? nxt : S_IDLE;
  // next state: fill ends on its last pixel, copy/blit end once the write stage has drained
  always_comb begin
    nxt = state == S_IDLE ? (accept ? op_state(op_in) : S_IDLE)
        : state == S_FILL ? (last ? S_IDLE : S_FILL)
        : (rd_active ? state : S_IDLE);
  end
  // operand latch, read stage flag, one-deep write pipeline and done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd       <= '0;
      rd_active <= 1'b0;
      wr_valid  <= 1'b0;
      wr_pix    <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept) cmd <= '{page_a: bus.cmd_page_a, page_b: bus.cmd_page_b, color: bus.cmd_color};
      rd_active <= accept ? (op_in == VOP_COPY || op_in == VOP_BLIT) : rd_active && !last;
      wr_valid  <= rd_active;
      wr_pix    <= pix;
      done_q    <= (state != S_IDLE && nxt == S_IDLE) || (accept && op_in == VOP_RSVD);
    end
  end
  // outputs: everything idles at zero, only the active op's write port moves
  always_comb begin
    bus.cmd_ready  = state == S_IDLE && reset;
    bus.busy       = state != S_IDLE;
    bus.done       = done_q;
    bus.page_raddr = rd_active ? {cmd.page_a, pix} : '0;
    bus.page_we    = state == S_FILL || (state == S_COPY && wr_valid);
    bus.page_waddr = state == S_FILL ? {cmd.page_a, pix}
                   : state == S_COPY && wr_valid ? {cmd.page_b, wr_pix} : '0;
    bus.page_wdata = state == S_FILL ? cmd.color
                   : state == S_COPY && wr_valid ? bus.page_rdata : '0;
    bus.disp_we    = state == S_BLIT && wr_valid;
    bus.disp_waddr = state == S_BLIT && wr_valid ? wr_pix : '0;
    bus.disp_wdata = state == S_BLIT && wr_valid ? bus.page_rdata : '0;
  end
endmodule

// File: tb/tb_anotherworld_video_engine.sv
// tb_anotherworld_video_engine: directed plus random fill/copy/blit checks against a page-array model
module tb_anotherworld_video_engine;
  localparam int N = 16, W = 5, PG = 32, BN = 64000, BW = 16;
  typedef struct {int cyc; int addr; int data; bit disp;} wr_t;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  anotherworld_video_engine_if #(.PIX_W(W))  bus ();
  anotherworld_video_engine_if #(.PIX_W(BW)) bbus ();
  anotherworld_video_engine #(.PAGE_PIXELS(N), .PIX_W(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  anotherworld_video_engine #(.PAGE_PIXELS(BN), .PIX_W(BW)) dut_big (.clk(clk), .reset(reset), .bus(bbus.slave));
  assign bbus.page_rdata = '0;

  logic [3:0] mem [0:4*PG-1];
  logic [3:0] dmem [0:PG-1];
  int exp_mem [0:4*PG-1];
  int exp_disp [0:PG-1];
  wr_t wlog[$];
  wr_t exp_q[$];
  int cyc = 0, both_cnt = 0, done_cnt = 0;
  int passed = 0, total = 0;
  int bcnt = 0, bfirst = -1, blast = -1, bbad = 0, bdisp = 0, bcol = 0;

  // sync-read page RAM and display buffer
  always @(posedge clk) begin
    bus.page_rdata <= mem[bus.page_raddr];
    if (bus.page_we) mem[bus.page_waddr] <= bus.page_wdata;
    if (bus.disp_we) dmem[bus.disp_waddr] <= bus.disp_wdata;
  end
  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;
  // write monitors
  always @(negedge clk) begin
    if (bus.page_we) wlog.push_back(wr_t'{cyc, int'(bus.page_waddr), int'(bus.page_wdata), 1'b0});
    if (bus.disp_we) wlog.push_back(wr_t'{cyc, int'(bus.disp_waddr), int'(bus.disp_wdata), 1'b1});
    if (bus.page_we && bus.disp_we) both_cnt++;
    if (bus.done) done_cnt++;
    if (bbus.page_we) begin
      if (bcnt == 0) bfirst = int'(bbus.page_waddr);
      blast = int'(bbus.page_waddr);
      if (int'(bbus.page_wdata) != bcol) bbad++;
      bcnt++;
    end
    if (bbus.disp_we) bdisp++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // reference: what each op must write and when, plus the resulting page/display contents
  task automatic model(input int op, input int a, input int b, input int c, input int acc, output int dexp);
    for (int i = 0; i < N; i++) begin
      if (op == 0) begin
        exp_q.push_back(wr_t'{acc + 1 + i, a * PG + i, c, 1'b0});
        exp_mem[a * PG + i] = c;
      end else if (op == 1) begin
        int d = exp_mem[a * PG + i];
        exp_q.push_back(wr_t'{acc + 2 + i, b * PG + i, d, 1'b0});
        exp_mem[b * PG + i] = d;
      end else if (op == 2) begin
        exp_q.push_back(wr_t'{acc + 2 + i, i, exp_mem[a * PG + i], 1'b1});
        exp_disp[i] = exp_mem[a * PG + i];
      end
    end
    dexp = op == 0 ? acc + N + 1 : op == 3 ? acc + 1 : acc + N + 2;
  endtask

  task automatic issue(input int op, input int a, input int b, input int c, output int acc);
    int t = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'(op); bus.cmd_page_a = 2'(a);
    bus.cmd_page_b = 2'(b); bus.cmd_color = 4'(c);
    while (!bus.cmd_ready && t < 100) begin @(negedge clk); t++; end
    check("accept_in_time", int'(t < 100), 1);
    acc = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'($urandom); bus.cmd_page_a = 2'($urandom);
    bus.cmd_page_b = 2'($urandom); bus.cmd_color = 4'($urandom);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int t = 0; t < 200 && dc < 0; t++) begin
      @(negedge clk);
      if (bus.done) dc = cyc;
    end
  endtask

  task automatic compare(input string tag);
    int bad = 0;
    repeat (2) @(negedge clk);
    check({tag, "_nwrites"}, wlog.size(), exp_q.size());
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
      if (wlog[i].cyc != exp_q[i].cyc || wlog[i].addr != exp_q[i].addr ||
          wlog[i].data != exp_q[i].data || wlog[i].disp != exp_q[i].disp) bad++;
    check({tag, "_log_errs"}, bad, 0);
    bad = 0;
    for (int i = 0; i < 4 * PG; i++) if (int'(mem[i]) != exp_mem[i]) bad++;
    for (int i = 0; i < PG; i++) if (int'(dmem[i]) != exp_disp[i]) bad++;
    check({tag, "_mem_errs"}, bad, 0);
    wlog.delete(); exp_q.delete();
  endtask

  task automatic run_cmd(input int op, input int a, input int b, input int c, input string tag);
    int acc, dexp, dc;
    issue(op, a, b, c, acc);
    model(op, a, b, c, acc, dexp);
    wait_done(dc);
    check({tag, "_done_cyc"}, dc, dexp);
    compare(tag);
  endtask

  initial begin
    int acc1, acc2, d1, d2, dc, d0, t;
    int a1, b1, a2, bp;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_page_a = '0; bus.cmd_page_b = '0; bus.cmd_color = '0;
    bbus.cmd_valid = 1'b0; bbus.cmd_op = '0; bbus.cmd_page_a = '0; bbus.cmd_page_b = '0; bbus.cmd_color = '0;
    for (int i = 0; i < 4 * PG; i++) begin mem[i] = 4'($urandom); exp_mem[i] = int'(mem[i]); end
    for (int i = 0; i < PG; i++) begin dmem[i] = 4'($urandom); exp_disp[i] = int'(dmem[i]); end
    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus.cmd_ready), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_we", int'(bus.page_we) + int'(bus.disp_we), 0);
    check("rst_addr", int'(bus.page_raddr) + int'(bus.page_waddr) + int'(bus.disp_waddr), 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(bus.cmd_ready), 1);

    run_cmd(0, 2, 0, 10, "fill_p2");
    for (int i = 0; i < PG; i++) begin mem[PG + i] = 4'(i); exp_mem[PG + i] = i & 15; end
    run_cmd(1, 1, 3, 0, "copy_1to3");
    run_cmd(2, 0, 0, 0, "blit_p0");
    run_cmd(1, 2, 2, 0, "copy_same");
    run_cmd(3, 1, 2, 5, "rsvd");

    // back-to-back: valid held high, second command taken in the done cycle
    a1 = int'($urandom_range(0, 3)); b1 = (a1 + 1) % 4; a2 = b1;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_page_a = 2'(a1); bus.cmd_page_b = 2'(b1);
    acc1 = cyc;
    check("b2b_first_ready", int'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_op = 2'd2; bus.cmd_page_a = 2'(a2); bus.cmd_page_b = 2'($urandom);
    model(1, a1, b1, 0, acc1, d1);
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.cmd_ready && t < 100);
    check("b2b_done_at_accept", int'(bus.done), 1);
    acc2 = cyc;
    check("b2b_accept_cyc", acc2, d1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    model(2, a2, 0, 0, acc2, d2);
    wait_done(dc);
    check("b2b_done2_cyc", dc, d2);
    compare("b2b");

    // reset in cycle 7 of a fill aborts it without a done pulse
    d0 = done_cnt;
    issue(0, 1, 0, 5, acc1);
    while (cyc < acc1 + 7) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(wr_t'{acc1 + 1 + i, PG + i, 5, 1'b0});
      exp_mem[PG + i] = 5;
    end
    @(negedge clk);
    check("abort_we", int'(bus.page_we), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_ready_low", int'(bus.cmd_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", int'(bus.cmd_ready), 1);
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, d0);
    compare("abort");

    for (int r = 0; r < 10; r++)
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)), $sformatf("rnd%0d", r));
    check("never_both_we", both_cnt, 0);

    // one full-size fill
    bp = int'($urandom_range(0, 3)); bcol = int'($urandom_range(0, 15));
    @(negedge clk);
    bbus.cmd_valid = 1'b1; bbus.cmd_op = 2'd0; bbus.cmd_page_a = 2'(bp); bbus.cmd_color = 4'(bcol);
    check("big_ready", int'(bbus.cmd_ready), 1);
    acc1 = cyc;
    @(posedge clk); #1;
    bbus.cmd_valid = 1'b0; bbus.cmd_color = 4'(bcol + 1);
    dc = -1;
    for (int i = 0; i < 70000 && dc < 0; i++) begin
      @(negedge clk);
      if (bbus.done) dc = cyc;
    end
    check("big_done_cyc", dc, acc1 + BN + 1);
    @(negedge clk);
    check("big_nwrites", bcnt, BN);
    check("big_first_addr", bfirst, bp << BW);
    check("big_last_addr", blast, (bp << BW) | (BN - 1));
    check("big_data_errs", bbad, 0);
    check("big_no_disp", bdisp, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
